// File: rtl/serial_packet_rx.sv
// serial_packet_rx: receiver and decoder for the ALU serial command link.
// Deserialises 11-bit frames, assembles DATA_BYTES data bytes plus a command
// byte, checks CRC (x^4+x+1) and opcode, and presents the packet on valid/ready.
// Optional feature: define SERIAL_PACKET_RX_TIMEOUT_EN to flush partial packets
// after TIMEOUT_CYCLES idle cycles.
module serial_packet_rx #(
  parameter int unsigned DATA_BYTES     = 8,
  parameter logic [7:0]  OP_VALID_MASK  = 8'h33,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sin,
  output logic [8*DATA_BYTES-1:0] pkt_data,
  output logic [2:0]              pkt_op,
  output logic [3:0]              pkt_crc,
  output logic                    err_data,
  output logic                    err_crc,
  output logic                    err_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int unsigned PKT_W = 8 * DATA_BYTES;
  localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);

  // Elaboration-time parameter range guard
  if (DATA_BYTES == 0 || DATA_BYTES > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("serial_packet_rx: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_BITS, S_STOP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q;
  logic             is_cmd_q;
  logic [7:0]       byte_q;
  logic [PKT_W-1:0] sr_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             excess_q;
  logic             corrupt_q;
  logic [3:0]       crc_q;

  logic       frame_ok_c, frame_err_c;
  logic       data_done_c, cmd_done_c, timeout_c, close_c;
  logic [2:0] op_c;
  logic [3:0] crc_rx_c, crc_calc_c;
  logic       err_data_c, err_crc_c, err_op_c;

  // One serial CRC step, MSB first
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  // Bit FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Bit FSM next state and frame-end decode
  always_comb begin
    state_d     = state_q;
    frame_ok_c  = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      S_IDLE: if (!sin) state_d = S_BITS;
      S_BITS: if (bit_cnt_q == 4'd8) state_d = S_STOP;
      S_STOP: begin
        state_d     = S_IDLE;
        frame_ok_c  = sin;
        frame_err_c = !sin;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Packet close decode and error classification (data > crc > op)
  always_comb begin
    data_done_c = frame_ok_c && !is_cmd_q;
    cmd_done_c  = frame_ok_c && is_cmd_q;
    close_c     = cmd_done_c || timeout_c;
    op_c        = byte_q[6:4];
    crc_rx_c    = byte_q[3:0];
    crc_calc_c  = crc_step(crc_step(crc_step(crc_step(crc_q, 1'b1), op_c[2]), op_c[1]), op_c[0]);
    err_data_c  = (byte_cnt_q != CNT_W'(DATA_BYTES)) || excess_q || corrupt_q;
    err_crc_c   = !err_data_c && (crc_rx_c != crc_calc_c);
    err_op_c    = !err_data_c && !err_crc_c && !OP_VALID_MASK[op_c];
  end

`ifdef SERIAL_PACKET_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q;
  logic            idle_run_c;

  assign idle_run_c = (state_q == S_IDLE) && sin && (byte_cnt_q != '0);
  assign timeout_c  = idle_run_c && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle gap counter for partial packets; any start bit clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        idle_cnt_q <= '0;
    else if (idle_run_c && !timeout_c) idle_cnt_q <= idle_cnt_q + TO_W'(1);
    else                               idle_cnt_q <= '0;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Frame deserialiser and packet assembly state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      is_cmd_q   <= 1'b0;
      byte_q     <= '0;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      excess_q   <= 1'b0;
      corrupt_q  <= 1'b0;
      crc_q      <= '0;
    end else begin
      if (state_q == S_BITS) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd0) begin
          is_cmd_q <= sin;
        end else begin
          byte_q <= {byte_q[6:0], sin};
          if (!is_cmd_q) crc_q <= crc_step(crc_q, sin);
        end
      end else begin
        bit_cnt_q <= '0;
      end
      if (data_done_c) begin
        if (byte_cnt_q == CNT_W'(DATA_BYTES)) begin
          excess_q <= 1'b1;
        end else begin
          sr_q       <= PKT_W'({sr_q, byte_q});
          byte_cnt_q <= byte_cnt_q + CNT_W'(1);
        end
      end
      if (frame_err_c) corrupt_q <= 1'b1;
      if (close_c) begin
        sr_q       <= '0;
        byte_cnt_q <= '0;
        excess_q   <= 1'b0;
        corrupt_q  <= 1'b0;
        crc_q      <= '0;
      end
    end
  end

  // Output register with valid/ready handshake and overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_data  <= '0;
      pkt_op    <= '0;
      pkt_crc   <= '0;
      err_data  <= 1'b0;
      err_crc   <= 1'b0;
      err_op    <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (close_c) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          pkt_data  <= sr_q;
          pkt_op    <= cmd_done_c ? op_c : 3'd0;
          pkt_crc   <= cmd_done_c ? crc_rx_c : 4'd0;
          err_data  <= timeout_c || err_data_c;
          err_crc   <= cmd_done_c && err_crc_c;
          err_op    <= cmd_done_c && err_op_c;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_packet_rx.sv
// Testbench for serial_packet_rx: directed table, multi-cycle corner cases,
// and randomized packets against a transaction-level reference model.
module tb_serial_packet_rx;

  localparam int unsigned DB      = 8;
  localparam int unsigned PW      = 8 * DB;
  localparam logic [7:0]  OP_MASK = 8'h33;

  logic          clk = 1'b0;
  logic          rst_n, sin, out_ready;
  logic [PW-1:0] pkt_data;
  logic [2:0]    pkt_op;
  logic [3:0]    pkt_crc;
  logic          err_data, err_crc, err_op, out_valid, overrun;

  serial_packet_rx #(.DATA_BYTES(DB), .OP_VALID_MASK(OP_MASK), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .pkt_data(pkt_data), .pkt_op(pkt_op), .pkt_crc(pkt_crc),
    .err_data(err_data), .err_crc(err_crc), .err_op(err_op),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] data;
    logic [2:0]    op;
    logic [3:0]    crc;
    logic          ed;
    logic          ec;
    logic          eo;
  } pkt_t;

  typedef struct {
    int         nb;
    logic [7:0] fill;
    logic [7:0] cmd;
    pkt_t       exp;
  } vec_t;

  int   vectors     = 0;
  int   miscompares = 0;
  logic m_valid     = 1'b0;
  logic m_ovr       = 1'b0;
  logic close_now   = 1'b0;
  logic rand_ready  = 1'b0;
  logic fix_ready   = 1'b1;
  pkt_t m_pkt, close_pkt, dummy;
  vec_t tbl[7];

  function automatic pkt_t mk_pkt(logic [PW-1:0] d, logic [2:0] op, logic [3:0] crc,
                                  logic ed, logic ec, logic eo);
    pkt_t p;
    p.data = d; p.op = op; p.crc = crc; p.ed = ed; p.ec = ec; p.eo = eo;
    return p;
  endfunction

  function automatic vec_t mk_vec(int nb, logic [7:0] fill, logic [7:0] cmd, pkt_t e);
    vec_t v;
    v.nb = nb; v.fill = fill; v.cmd = cmd; v.exp = e;
    return v;
  endfunction

  // CRC as remainder of (message * x^4) mod x^4+x+1 by polynomial long division
  function automatic logic [3:0] crc_ref(input logic [7:0] bytes[$], input logic [2:0] op);
    bit         msg[$];
    logic [4:0] rem;
    logic [7:0] b;
    foreach (bytes[i]) begin
      b = bytes[i];
      for (int k = 7; k >= 0; k--) msg.push_back(b[k]);
    end
    msg.push_back(1'b1);
    for (int k = 2; k >= 0; k--) msg.push_back(op[k]);
    for (int k = 0; k < 4; k++) msg.push_back(1'b0);
    rem = '0;
    foreach (msg[j]) begin
      rem = {rem[3:0], msg[j]};
      if (rem[4]) rem = rem ^ 5'b10011;
    end
    return rem[3:0];
  endfunction

  function automatic pkt_t ref_pkt(input logic [7:0] bytes[$], input logic [7:0] cmd);
    pkt_t p;
    p.data = '0;
    for (int i = 0; i < bytes.size() && i < DB; i++) p.data = (p.data << 8) | PW'(bytes[i]);
    p.op  = cmd[6:4];
    p.crc = cmd[3:0];
    p.ed  = (bytes.size() != DB);
    p.ec  = !p.ed && (crc_ref(bytes, p.op) != p.crc);
    p.eo  = !p.ed && !p.ec && !OP_MASK[p.op];
    return p;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", PW'(out_valid), PW'(m_valid));
    check("overrun", PW'(overrun), PW'(m_ovr));
    if (m_valid) begin
      check("pkt_data", pkt_data, m_pkt.data);
      check("pkt_op", PW'(pkt_op), PW'(m_pkt.op));
      check("pkt_crc", PW'(pkt_crc), PW'(m_pkt.crc));
      check("err_data", PW'(err_data), PW'(m_pkt.ed));
      check("err_crc", PW'(err_crc), PW'(m_pkt.ec));
      check("err_op", PW'(err_op), PW'(m_pkt.eo));
    end
  endtask

  // One serial bit: drive, clock, update the handshake model, compare
  task automatic tick(input logic b);
    logic rdy;
    sin = b;
    @(posedge clk);
    rdy   = out_ready;
    m_ovr = 1'b0;
    if (close_now) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_pkt   = close_pkt;
      end else begin
        m_ovr = 1'b1;
      end
      close_now = 1'b0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
    compare_outputs();
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] b, input logic closing, input pkt_t p);
    tick(1'b0);
    tick(typ);
    for (int i = 7; i >= 0; i--) tick(b[i]);
    if (closing) begin
      close_now = 1'b1;
      close_pkt = p;
    end
    tick(1'b1);
  endtask

  task automatic send_packet(input logic [7:0] bytes[$], input logic [7:0] cmd, input pkt_t p,
                             input int max_gap);
    foreach (bytes[i]) begin
      send_frame(1'b0, bytes[i], 1'b0, p);
      for (int g = $urandom_range(0, max_gap); g > 0; g--) tick(1'b1);
    end
    send_frame(1'b1, cmd, 1'b1, p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sin   = 1'b1;
    #2;
    m_valid = 1'b0; m_ovr = 1'b0; close_now = 1'b0;
    check("rst_out_valid", PW'(out_valid), '0);
    check("rst_overrun", PW'(overrun), '0);
    check("rst_pkt_data", pkt_data, '0);
    check("rst_pkt_op", PW'(pkt_op), '0);
    check("rst_pkt_crc", PW'(pkt_crc), '0);
    check("rst_errs", PW'({err_data, err_crc, err_op}), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] bytes[$];
    logic [7:0] cmd;
    logic [2:0] op;
    pkt_t       p;
    int         nb, r;

    tbl[0] = mk_vec(8, 8'h00, 8'h0B, mk_pkt('0, 3'd0, 4'hB, 1'b0, 1'b0, 1'b0));
    tbl[1] = mk_vec(8, 8'h00, 8'h0C, mk_pkt('0, 3'd0, 4'hC, 1'b0, 1'b1, 1'b0));
    tbl[2] = mk_vec(8, 8'h00, 8'h2D, mk_pkt('0, 3'd2, 4'hD, 1'b0, 1'b0, 1'b1));
    tbl[3] = mk_vec(7, 8'h00, 8'h0B, mk_pkt('0, 3'd0, 4'hB, 1'b1, 1'b0, 1'b0));
    tbl[4] = mk_vec(9, 8'h00, 8'h0B, mk_pkt('0, 3'd0, 4'hB, 1'b1, 1'b0, 1'b0));
    tbl[5] = mk_vec(8, 8'h00, 8'h47, mk_pkt('0, 3'd4, 4'h7, 1'b0, 1'b0, 1'b0));
    tbl[6] = mk_vec(8, 8'h00, 8'h54, mk_pkt('0, 3'd5, 4'h4, 1'b0, 1'b0, 1'b0));
    dummy  = mk_pkt('0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; sin = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed table, consumer always ready
    fix_ready = 1'b1; out_ready = 1'b1;
    tick(1'b1);
    for (int v = 0; v < 7; v++) begin
      bytes = {};
      for (int i = 0; i < tbl[v].nb; i++) bytes.push_back(tbl[v].fill);
      send_packet(bytes, tbl[v].cmd, tbl[v].exp, 0);
      tick(1'b1); tick(1'b1);
    end

    // Back-to-back packets with a stalled consumer: first held, second dropped
    fix_ready = 1'b0; out_ready = 1'b0;
    bytes = {};
    for (int i = 0; i < DB; i++) bytes.push_back(8'h00);
    send_packet(bytes, 8'h0B, tbl[0].exp, 0);
    send_packet(bytes, 8'h0B, mk_pkt('1, 3'd7, 4'hF, 1'b1, 1'b1, 1'b1), 0);
    for (int i = 0; i < 3; i++) tick(1'b1);
    // Third packet interrupted by reset mid-frame
    send_frame(1'b0, 8'hA5, 1'b0, dummy);
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);
    do_reset();
    fix_ready = 1'b1; out_ready = 1'b1;
    bytes = {};
    for (int i = 0; i < DB; i++) bytes.push_back(8'(8'h10 + i));
    cmd = {1'b0, 3'd1, crc_ref(bytes, 3'd1)};
    send_packet(bytes, cmd, ref_pkt(bytes, cmd), 0);
    tick(1'b1); tick(1'b1);

    // Partial packet followed by a long idle gap
    bytes = '{8'h11, 8'h22, 8'h33};
    foreach (bytes[i]) send_frame(1'b0, bytes[i], 1'b0, dummy);
`ifdef SERIAL_PACKET_RX_TIMEOUT_EN
    for (int i = 0; i < 63; i++) tick(1'b1);
    close_now = 1'b1;
    close_pkt = mk_pkt(PW'(24'h112233), 3'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1);
    bytes = {};
`else
    for (int i = 0; i < 70; i++) tick(1'b1);
`endif
    send_frame(1'b1, 8'h0B, 1'b1, ref_pkt(bytes, 8'h0B));
    tick(1'b1); tick(1'b1);

    // Randomized packets with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 5);
      nb = (r == 0) ? DB - 1 : (r == 1) ? DB + 1 : DB;
      bytes = {};
      for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
      op  = 3'($urandom_range(0, 7));
      cmd = {1'b0, op, ($urandom_range(0, 3) != 0) ? crc_ref(bytes, op) : 4'($urandom)};
      send_packet(bytes, cmd, ref_pkt(bytes, cmd), 2);
      for (int g = $urandom_range(0, 3); g > 0; g--) tick(1'b1);
    end
    rand_ready = 1'b0; fix_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_packet_rx.md
Name: serial_packet_rx

Overview:
- Synthesizable receiver and decoder for the ALU serial command link.
- Deserialises 11-bit frames on `sin`, assembles a parametrised number of data bytes plus one command byte, and checks the 4-bit CRC and the opcode.
- Presents a decoded packet with an error classification over a valid/ready handshake.
- Sits between the serial pin and the ALU core, or serves as the command monitor front-end in the bench.

Parameters:
- DATA_BYTES, 8: data bytes per packet (operand bytes B then A). Range 1..16.
- OP_VALID_MASK, 8'h33: bit i set means opcode i is legal (and=000, or=001, add=100, sub=101).
- TIMEOUT_CYCLES, 64: maximum idle cycles between frames of one packet. Used only with the optional feature.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- sin, in, 1: serial input, idle high, one bit per clk, synchronous to clk.
- pkt_data, out, 8*DATA_BYTES: data bytes; the first received byte is at the MSBs.
- pkt_op, out, 3: opcode field of the command byte.
- pkt_crc, out, 4: CRC field received in the command byte.
- err_data, out, 1: wrong data byte count or a frame error in the packet.
- err_crc, out, 1: CRC mismatch.
- err_op, out, 1: illegal opcode.
- out_valid, out, 1: packet available.
- out_ready, in, 1: consumer accepts the packet.
- overrun, out, 1: one-cycle pulse when a completed packet is dropped.

Behaviour:
- Frame format, 11 bits, sampled on posedge clk: start(0), type (0=data, 1=cmd), d[7:0] MSB first, stop(1). Command byte = {1'b0, op[2:0], crc[3:0]}.
- Bit FSM states and transitions:
  - IDLE: go to BITS when sin==0 is sampled.
  - BITS: 4-bit counter captures type plus 8 data bits.
  - STOP: sin==1 completes the frame; sin==0 is a frame error, which marks the packet corrupt. Either way, return to IDLE.
- Data frame: shift into pkt shift register and increment byte count.
  - Count saturates at DATA_BYTES.
  - A further data frame sets an excess flag and its byte is discarded.
- Command frame closes the packet. Error classification, with priority data > crc > op; exactly one err_* is set, or none:
  - err_data when count != DATA_BYTES, or the excess flag is set, or the packet is corrupt.
  - else err_crc when received crc != computed CRC.
  - else err_op when OP_VALID_MASK[op]==0.
- CRC: x^4+x+1, init 0, computed serially MSB first over all data bits in arrival order, then 1'b1, then op[2:0].
  - Per bit: fb = c[3]^d; c <= {c[2], c[1], c[0]^fb, fb}.
  - Data CRC updates during data frames; the 4 trailing bits {1, op} are folded in when the command frame completes (combinational unroll allowed).
- Output register:
  - out_valid rises on the clock edge that samples the command frame's stop bit. pkt_* and err_* are valid with it and held stable while out_valid && !out_ready.
  - Cleared the cycle after a cycle where out_valid && out_ready.
- After each command frame, the byte count, excess, corrupt and CRC state are cleared in the same cycle. Back-to-back packets with zero idle bits are supported.
- Packet completes while out_valid is still high and out_ready is low: new packet dropped, overrun pulses 1 cycle, held output unchanged.
  - If out_ready is high in that same cycle, the new packet replaces the old one with no overrun.
- Reset (any time, including mid-frame): FSM to IDLE; counters, CRC and all outputs 0; pkt_data 0.

Optional Feature:
- Macro: SERIAL_PACKET_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while in IDLE with byte count > 0.
  - Reaching TIMEOUT_CYCLES emits a packet with err_data=1, pkt_op=0, pkt_crc=0, and resets packet state. Overrun rules apply.
  - The counter is cleared by any start bit.
- Undefined: no counter. Partial packets wait indefinitely for a command frame.

Test Plan:
- 8 data bytes 0x00, cmd 0x0B, out_ready=1 -> pkt_data=0, pkt_op=000, pkt_crc=0xB, all err=0, out_valid 1 cycle.
- 8 data bytes 0x00, cmd 0x0C -> err_crc=1, err_op=0, err_data=0.
- 8 data bytes 0x00, cmd 0x2D (op 010, CRC correct) -> err_op=1 only.
- 7 data bytes then cmd 0x0B -> err_data=1. Also 9 data bytes then cmd 0x0B -> err_data=1.
- Two valid packets back-to-back, out_ready=0 -> first held, overrun pulse at the second command stop bit. Deassert rst_n mid-frame of a third packet -> all outputs 0, next full packet decodes correctly.
- With SERIAL_PACKET_RX_TIMEOUT_EN, TIMEOUT_CYCLES=64: 3 data bytes then 64 idle cycles -> out_valid with err_data=1. Without the macro -> no output.
